// File: rtl/pcie_ss_hdr_pkg.sv
// PCIe SS power-user header helpers: fmttype field location and message classification.
package pcie_ss_hdr_pkg;

  localparam int HDR_WIDTH = 8;

  typedef logic [HDR_WIDTH-1:0] fmttype_t;

  // Msg/MsgD: fmt = 001/011 and type[4:3] = 2'b10; the routing subfield is not constrained.
  function automatic logic is_msg_fmttype(input fmttype_t ft);
    return (ft[7] == 1'b0) && (ft[5] == 1'b1) && (ft[4:3] == 2'b10);
  endfunction

endpackage

// File: rtl/st2mm_pkg.sv
// Shared ST2MM definitions: TX arbiter states, source selectors and counter width.
package st2mm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_OWN_MMIO  = 2'd1,
    ST_OWN_UMSG  = 2'd2,
    ST_DROP_UMSG = 2'd3
  } arb_state_e;

  typedef enum logic {
    SRC_MMIO = 1'b0,
    SRC_UMSG = 1'b1
  } src_sel_e;

  localparam int DROP_CNT_WIDTH = 16;

endpackage

// File: rtl/st2mm_tx_pipe_reg.sv
// One-deep AXI-S register slice; only the valid flag is reset, payload is load-enabled.
module st2mm_tx_pipe_reg #(
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     up_tvalid,
  output logic                     up_tready,
  input  logic [TDATA_WIDTH-1:0]   up_tdata,
  input  logic [TDATA_WIDTH/8-1:0] up_tkeep,
  input  logic                     up_tlast,
  input  logic [TUSER_WIDTH-1:0]   up_tuser_vendor,
  output logic                     dn_tvalid,
  input  logic                     dn_tready,
  output logic [TDATA_WIDTH-1:0]   dn_tdata,
  output logic [TDATA_WIDTH/8-1:0] dn_tkeep,
  output logic                     dn_tlast,
  output logic [TUSER_WIDTH-1:0]   dn_tuser_vendor
);

  logic                     valid_reg;
  logic [TDATA_WIDTH-1:0]   data_reg;
  logic [TDATA_WIDTH/8-1:0] keep_reg;
  logic                     last_reg;
  logic [TUSER_WIDTH-1:0]   user_reg;

  assign up_tready = ~valid_reg | dn_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
    end else if (up_tready) begin
      valid_reg <= up_tvalid;
    end
  end

  always_ff @(posedge clk) begin
    if (up_tready && up_tvalid) begin
      data_reg <= up_tdata;
      keep_reg <= up_tkeep;
      last_reg <= up_tlast;
      user_reg <= up_tuser_vendor;
    end
  end

  assign dn_tvalid       = valid_reg;
  assign dn_tdata        = data_reg;
  assign dn_tkeep        = keep_reg;
  assign dn_tlast        = last_reg;
  assign dn_tuser_vendor = user_reg;

endmodule

// File: rtl/st2mm_tx_packet_mux.sv
// Packet-granular round-robin merge of MMIO completions and UMSG messages onto the TX stream,
// discarding UMSG packets whose first-beat fmttype is not a message.
module st2mm_tx_packet_mux
  import st2mm_pkg::*;
  import pcie_ss_hdr_pkg::*;
#(
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mmio_tvalid,
  output logic                      mmio_tready,
  input  logic [TDATA_WIDTH-1:0]    mmio_tdata,
  input  logic [TDATA_WIDTH/8-1:0]  mmio_tkeep,
  input  logic                      mmio_tlast,
  input  logic [TUSER_WIDTH-1:0]    mmio_tuser_vendor,
  input  logic                      umsg_tvalid,
  output logic                      umsg_tready,
  input  logic [TDATA_WIDTH-1:0]    umsg_tdata,
  input  logic [TDATA_WIDTH/8-1:0]  umsg_tkeep,
  input  logic                      umsg_tlast,
  input  logic [TUSER_WIDTH-1:0]    umsg_tuser_vendor,
  output logic                      tx_tvalid,
  input  logic                      tx_tready,
  output logic [TDATA_WIDTH-1:0]    tx_tdata,
  output logic [TDATA_WIDTH/8-1:0]  tx_tkeep,
  output logic                      tx_tlast,
  output logic [TUSER_WIDTH-1:0]    tx_tuser_vendor,
  output logic [DROP_CNT_WIDTH-1:0] umsg_drop_cnt
);

  arb_state_e                state_reg, state_next;
  src_sel_e                  rr_last_reg, rr_last_next;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_reg;

  src_sel_e                  sel;
  logic                      mmio_rdy, umsg_rdy, drop_start;
  logic                      umsg_is_msg;
  logic                      pipe_tvalid, pipe_tready;
  logic [TDATA_WIDTH-1:0]    pipe_tdata;
  logic [TDATA_WIDTH/8-1:0]  pipe_tkeep;
  logic                      pipe_tlast;
  logic [TUSER_WIDTH-1:0]    pipe_tuser;

  assign umsg_is_msg = is_msg_fmttype(umsg_tdata[HDR_WIDTH-1:0]);

  always_comb begin
    state_next   = state_reg;
    rr_last_next = rr_last_reg;
    sel          = SRC_MMIO;
    mmio_rdy     = 1'b0;
    umsg_rdy     = 1'b0;
    pipe_tvalid  = 1'b0;
    drop_start   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Winner's first beat is taken in the decision cycle, so there is no arbitration bubble.
        if (mmio_tvalid && (!umsg_tvalid || rr_last_reg == SRC_UMSG)) begin
          sel         = SRC_MMIO;
          mmio_rdy    = pipe_tready;
          pipe_tvalid = 1'b1;
          if (pipe_tready) begin
            if (mmio_tlast) rr_last_next = SRC_MMIO;
            else            state_next   = ST_OWN_MMIO;
          end
        end else if (umsg_tvalid) begin
          sel = SRC_UMSG;
          if (umsg_is_msg) begin
            umsg_rdy    = pipe_tready;
            pipe_tvalid = 1'b1;
            if (pipe_tready) begin
              if (umsg_tlast) rr_last_next = SRC_UMSG;
              else            state_next   = ST_OWN_UMSG;
            end
          end else begin
            // Dropped beats never touch the output slice, so they sink regardless of tx_tready.
            umsg_rdy   = 1'b1;
            drop_start = 1'b1;
            if (umsg_tlast) rr_last_next = SRC_UMSG;
            else            state_next   = ST_DROP_UMSG;
          end
        end
      end
      ST_OWN_MMIO: begin
        sel         = SRC_MMIO;
        mmio_rdy    = pipe_tready;
        pipe_tvalid = mmio_tvalid;
        if (mmio_tvalid && pipe_tready && mmio_tlast) begin
          state_next   = ST_IDLE;
          rr_last_next = SRC_MMIO;
        end
      end
      ST_OWN_UMSG: begin
        sel         = SRC_UMSG;
        umsg_rdy    = pipe_tready;
        pipe_tvalid = umsg_tvalid;
        if (umsg_tvalid && pipe_tready && umsg_tlast) begin
          state_next   = ST_IDLE;
          rr_last_next = SRC_UMSG;
        end
      end
      ST_DROP_UMSG: begin
        sel      = SRC_UMSG;
        umsg_rdy = 1'b1;
        if (umsg_tvalid && umsg_tlast) begin
          state_next   = ST_IDLE;
          rr_last_next = SRC_UMSG;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      rr_last_reg  <= SRC_UMSG;
      drop_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rr_last_reg <= rr_last_next;
      if (drop_start && drop_cnt_reg != '1) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

  // Readies are held low for the whole reset window, not just from the next edge.
  assign mmio_tready   = mmio_rdy & rst_n;
  assign umsg_tready   = umsg_rdy & rst_n;
  assign umsg_drop_cnt = drop_cnt_reg;

  assign pipe_tdata = (sel == SRC_UMSG) ? umsg_tdata        : mmio_tdata;
  assign pipe_tkeep = (sel == SRC_UMSG) ? umsg_tkeep        : mmio_tkeep;
  assign pipe_tlast = (sel == SRC_UMSG) ? umsg_tlast        : mmio_tlast;
  assign pipe_tuser = (sel == SRC_UMSG) ? umsg_tuser_vendor : mmio_tuser_vendor;

  st2mm_tx_pipe_reg #(
    .TDATA_WIDTH (TDATA_WIDTH),
    .TUSER_WIDTH (TUSER_WIDTH)
  ) u_pipe (
    .clk             (clk),
    .rst_n           (rst_n),
    .up_tvalid       (pipe_tvalid),
    .up_tready       (pipe_tready),
    .up_tdata        (pipe_tdata),
    .up_tkeep        (pipe_tkeep),
    .up_tlast        (pipe_tlast),
    .up_tuser_vendor (pipe_tuser),
    .dn_tvalid       (tx_tvalid),
    .dn_tready       (tx_tready),
    .dn_tdata        (tx_tdata),
    .dn_tkeep        (tx_tkeep),
    .dn_tlast        (tx_tlast),
    .dn_tuser_vendor (tx_tuser_vendor)
  );

endmodule

// File: tb/tb_st2mm_tx_packet_mux.sv
// Bench for st2mm_tx_packet_mux: packet-level reference (per-source expected queues,
// drop tally, arrival order) checked against the merged TX stream.
module tb_st2mm_tx_packet_mux;

  localparam int DW = 64;
  localparam int UW = 10;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mmio_tvalid = 1'b0, mmio_tready, mmio_tlast = 1'b0;
  logic [DW-1:0] mmio_tdata = '0;
  logic [KW-1:0] mmio_tkeep = '0;
  logic [UW-1:0] mmio_tuser_vendor = '0;
  logic          umsg_tvalid = 1'b0, umsg_tready, umsg_tlast = 1'b0;
  logic [DW-1:0] umsg_tdata = '0;
  logic [KW-1:0] umsg_tkeep = '0;
  logic [UW-1:0] umsg_tuser_vendor = '0;
  logic          tx_tvalid, tx_tready = 1'b1, tx_tlast;
  logic [DW-1:0] tx_tdata;
  logic [KW-1:0] tx_tkeep;
  logic [UW-1:0] tx_tuser_vendor;
  logic [15:0]   umsg_drop_cnt;

  always #5 clk = ~clk;

  st2mm_tx_packet_mux #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) dut (
    .clk (clk), .rst_n (rst_n),
    .mmio_tvalid (mmio_tvalid), .mmio_tready (mmio_tready), .mmio_tdata (mmio_tdata),
    .mmio_tkeep (mmio_tkeep), .mmio_tlast (mmio_tlast), .mmio_tuser_vendor (mmio_tuser_vendor),
    .umsg_tvalid (umsg_tvalid), .umsg_tready (umsg_tready), .umsg_tdata (umsg_tdata),
    .umsg_tkeep (umsg_tkeep), .umsg_tlast (umsg_tlast), .umsg_tuser_vendor (umsg_tuser_vendor),
    .tx_tvalid (tx_tvalid), .tx_tready (tx_tready), .tx_tdata (tx_tdata),
    .tx_tkeep (tx_tkeep), .tx_tlast (tx_tlast), .tx_tuser_vendor (tx_tuser_vendor),
    .umsg_drop_cnt (umsg_drop_cnt)
  );

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    run_start = 0;
  int    stall_cnt = 0;
  int    exp_drops = 0;
  int    exp_pkts = 0;
  int    out_src = -1;
  int    sink_owner = -1;
  int    out_len = 0;
  beat_t mm_q[$], um_q[$], exp_mm[$], exp_um[$];
  int    out_pkts[$], out_cyc[$], acc_cyc[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    mm_q.delete(); um_q.delete(); exp_mm.delete(); exp_um.delete();
    out_pkts.delete(); out_cyc.delete(); acc_cyc.delete();
    exp_drops = 0; exp_pkts = 0; out_src = -1; sink_owner = -1; out_len = 0; stall_cnt = 0;
  endtask

  // Reset with both sinks offering data: readies and outputs must already be quiet.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mmio_tvalid = 1'b1; umsg_tvalid = 1'b1; tx_tready = 1'b1;
    #1;
    chk("rst_tx_tvalid", 128'(tx_tvalid), 128'(0));
    chk("rst_mmio_tready", 128'(mmio_tready), 128'(0));
    chk("rst_umsg_tready", 128'(umsg_tready), 128'(0));
    chk("rst_drop_cnt", 128'(umsg_drop_cnt), 128'(0));
    repeat (2) @(negedge clk);
    mmio_tvalid = 1'b0; umsg_tvalid = 1'b0;
    rst_n = 1'b1;
    clear_model();
  endtask

  // Message fmttypes are Msg/MsgD (0x30-0x37, 0x70-0x77); anything else is a drop candidate.
  task automatic add_pkt(input int src, input int len, input bit msg);
    beat_t     b;
    logic [7:0] ft;
    if (src == 0) ft = 8'h4A;
    else if (msg) ft = ($urandom_range(0, 1) == 1 ? 8'h70 : 8'h30) | 8'($urandom_range(0, 7));
    else begin
      case ($urandom_range(0, 3))
        0: ft = 8'h40;
        1: ft = 8'h60;
        2: ft = 8'h00;
        default: ft = 8'h4A;
      endcase
    end
    for (int i = 0; i < len; i++) begin
      b.data    = {$urandom, $urandom};
      b.data[8] = (src == 1);
      if (i == 0) b.data[7:0] = ft;
      b.last = (i == len - 1);
      b.keep = b.last ? 8'($urandom_range(1, 255)) : '1;
      b.user = 10'($urandom);
      if (src == 0) begin mm_q.push_back(b); exp_mm.push_back(b); end
      else begin um_q.push_back(b); if (msg) exp_um.push_back(b); end
    end
    if (src == 1 && !msg) exp_drops++;
    else exp_pkts++;
  endtask

  task automatic take_out(input beat_t b);
    int    s;
    beat_t e;
    s = b.data[8] ? 1 : 0;
    out_cyc.push_back(cyc);
    if (out_src == -1) out_src = s;
    else chk("out_no_interleave", 128'(s), 128'(out_src));
    out_len++;
    if (s == 0) begin
      chk("out_mmio_expected", 128'(exp_mm.size() > 0), 128'(1));
      if (exp_mm.size() > 0) begin e = exp_mm.pop_front(); chk("out_mmio_beat", 128'(b), 128'(e)); end
    end else begin
      chk("out_umsg_expected", 128'(exp_um.size() > 0), 128'(1));
      if (exp_um.size() > 0) begin e = exp_um.pop_front(); chk("out_umsg_beat", 128'(b), 128'(e)); end
    end
    if (b.last) begin
      $display("[%0d] tx packet src=%s beats=%0d", cyc, out_src == 0 ? "mmio" : "umsg", out_len);
      out_pkts.push_back(out_src);
      out_src = -1;
      out_len = 0;
    end
  endtask

  // rdy_mode: 0 always ready, 1 random, 2 per-cycle mask, 3 never ready.
  task automatic run(input int max_cyc, input int rdy_mode, input logic [63:0] rdy_mask,
                     input bit rnd_valid, input bit until_done);
    bit    mv, uv, mm_acc, um_acc, out_acc, prev_stall, done;
    beat_t ob, prev_out;
    int    s;
    mv = 0; uv = 0; prev_stall = 0; done = 0; prev_out = '0;
    run_start = cyc;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (!mv) mv = (mm_q.size() > 0) && (!rnd_valid || $urandom_range(0, 3) != 0);
      if (!uv) uv = (um_q.size() > 0) && (!rnd_valid || $urandom_range(0, 3) != 0);
      mmio_tvalid = mv;
      {mmio_tdata, mmio_tkeep, mmio_tlast, mmio_tuser_vendor} = mv ? mm_q[0] : '0;
      umsg_tvalid = uv;
      {umsg_tdata, umsg_tkeep, umsg_tlast, umsg_tuser_vendor} = uv ? um_q[0] : '0;
      case (rdy_mode)
        0: tx_tready = 1'b1;
        1: tx_tready = ($urandom_range(0, 2) != 0);
        2: tx_tready = (c < 64) ? rdy_mask[c] : 1'b1;
        default: tx_tready = 1'b0;
      endcase
      #2;
      mm_acc  = mmio_tvalid && mmio_tready;
      um_acc  = umsg_tvalid && umsg_tready;
      out_acc = tx_tvalid && tx_tready;
      ob      = {tx_tdata, tx_tkeep, tx_tlast, tx_tuser_vendor};
      chk("ready_exclusive", 128'(mmio_tready & umsg_tready), 128'(0));
      if (prev_stall) begin
        chk("stall_tvalid_held", 128'(tx_tvalid), 128'(1));
        chk("stall_payload_stable", 128'(ob), 128'(prev_out));
      end
      prev_stall = tx_tvalid && !tx_tready;
      if (prev_stall) stall_cnt++;
      prev_out = ob;
      if (mm_acc || um_acc) begin
        s = mm_acc ? 0 : 1;
        acc_cyc.push_back(cyc);
        if (sink_owner != -1) chk("sink_no_interleave", 128'(s), 128'(sink_owner));
        sink_owner = ((s == 0 ? mmio_tlast : umsg_tlast) == 1'b1) ? -1 : s;
      end
      if (out_acc) take_out(ob);
      @(posedge clk);
      cyc++;
      if (mm_acc) begin void'(mm_q.pop_front()); mv = 0; end
      if (um_acc) begin void'(um_q.pop_front()); uv = 0; end
      if (until_done && mm_q.size() == 0 && um_q.size() == 0 &&
          exp_mm.size() == 0 && exp_um.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (until_done) begin
      chk("drain_within_budget", 128'(done), 128'(1));
      @(negedge clk);
      mmio_tvalid = 1'b0; umsg_tvalid = 1'b0; tx_tready = 1'b1;
    end
  endtask

  initial begin
    // Reset state, then two single-beat packets: no bubble, 1-cycle latency, FSM back in IDLE.
    do_reset();
    add_pkt(0, 1, 0);
    add_pkt(1, 1, 1);
    run(50, 0, '1, 0, 1);
    chk("single_first_accept_cycle", 128'(acc_cyc[0]), 128'(run_start));
    chk("single_second_accept_next", 128'(acc_cyc[1] - acc_cyc[0]), 128'(1));
    chk("single_latency", 128'(out_cyc[0] - acc_cyc[0]), 128'(1));
    chk("single_order", 128'({out_pkts[0][0], out_pkts[1][0]}), 128'(2'b01));

    // Simultaneous 3-beat packets: MMIO wins first tie, six back-to-back beats.
    do_reset();
    add_pkt(0, 3, 0);
    add_pkt(1, 3, 1);
    run(50, 0, '1, 0, 1);
    chk("tie_pkt_count", 128'(out_pkts.size()), 128'(2));
    chk("tie_first_mmio", 128'(out_pkts[0]), 128'(0));
    chk("tie_second_umsg", 128'(out_pkts[1]), 128'(1));
    chk("tie_beats_contiguous", 128'(out_cyc[5] - out_cyc[0]), 128'(5));

    // Continuous contention with 2-beat packets alternates strictly.
    do_reset();
    for (int i = 0; i < 4; i++) begin add_pkt(0, 2, 0); add_pkt(1, 2, 1); end
    run(100, 0, '1, 0, 1);
    chk("alt_pkt_count", 128'(out_pkts.size()), 128'(8));
    for (int i = 0; i < 8 && i < out_pkts.size(); i++) chk("alt_order", 128'(out_pkts[i]), 128'(i % 2));
    chk("alt_beats_contiguous", 128'(out_cyc[15] - out_cyc[0]), 128'(15));

    // Non-message UMSG: consumed one beat per cycle even with TX stalled, nothing forwarded.
    do_reset();
    add_pkt(1, 4, 0);
    run(50, 3, '1, 0, 1);
    chk("drop_accepts", 128'(acc_cyc.size()), 128'(4));
    chk("drop_first_cycle", 128'(acc_cyc[0]), 128'(run_start));
    chk("drop_consecutive", 128'(acc_cyc[3] - acc_cyc[0]), 128'(3));
    chk("drop_no_output", 128'(out_cyc.size()), 128'(0));
    chk("drop_cnt_one", 128'(umsg_drop_cnt), 128'(exp_drops));

    // Five-cycle TX stall inside a 4-beat MMIO packet; queued UMSG waits its turn.
    do_reset();
    add_pkt(0, 4, 0);
    add_pkt(1, 2, 1);
    run(100, 2, 64'hFFFF_FFFF_FFFF_FF83, 0, 1);
    chk("stall_cycles", 128'(stall_cnt), 128'(5));
    chk("stall_pkt_count", 128'(out_pkts.size()), 128'(2));
    chk("stall_order", 128'({out_pkts[0][0], out_pkts[1][0]}), 128'(2'b01));

    // Reset in the middle of a UMSG packet abandons it.
    do_reset();
    add_pkt(1, 4, 1);
    run(2, 0, '1, 0, 0);
    @(negedge clk);
    chk("pre_rst_tvalid", 128'(tx_tvalid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 128'(tx_tvalid), 128'(0));
    chk("mid_rst_umsg_tready", 128'(umsg_tready), 128'(0));
    repeat (2) @(negedge clk);
    mmio_tvalid = 1'b0; umsg_tvalid = 1'b0;
    clear_model();
    rst_n = 1'b1;
    add_pkt(0, 2, 0);
    run(50, 0, '1, 0, 1);
    chk("post_rst_pkt_count", 128'(out_pkts.size()), 128'(1));
    chk("post_rst_pkt_src", 128'(out_pkts[0]), 128'(0));

    // Randomized traffic: lengths, message/non-message mix, valid gaps and TX backpressure.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      add_pkt(0, $urandom_range(1, 5), 0);
      add_pkt(1, $urandom_range(1, 5), $urandom_range(0, 2) != 0);
    end
    run(4000, 1, '1, 1, 1);
    chk("rand_pkt_count", 128'(out_pkts.size()), 128'(exp_pkts));
    chk("rand_drop_cnt", 128'(umsg_drop_cnt), 128'(exp_drops));

    // Saturation: a stream of single-beat non-message UMSG packets, one dropped per cycle.
    do_reset();
    @(negedge clk);
    umsg_tvalid = 1'b1; umsg_tlast = 1'b1; umsg_tdata = 64'h40; tx_tready = 1'b1;
    repeat (1000) @(negedge clk);
    chk("drop_cnt_1000", 128'(umsg_drop_cnt), 128'(1000));
    repeat (64540) @(negedge clk);
    chk("drop_cnt_saturated", 128'(umsg_drop_cnt), 128'(16'hFFFF));
    repeat (3) @(negedge clk);
    chk("drop_cnt_held", 128'(umsg_drop_cnt), 128'(16'hFFFF));
    chk("drop_stream_no_output", 128'(tx_tvalid), 128'(0));
    umsg_tvalid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/st2mm_tx_packet_mux.md
ST2MM_TX_PACKET_MUX -- requirements
Module: st2mm_tx_packet_mux

Interface
REQ-001 Parameter TDATA_WIDTH, default 512, AXI-S data width of all three streams.
REQ-002 Parameter TUSER_WIDTH, default 10, tuser_vendor width of all three streams.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 mmio_st_if  pcie_ss_axis_if.sink  TDATA/TUSER  MMIO completion packets from ST2MM MMIO engine.
REQ-006 umsg_st_if  pcie_ss_axis_if.sink  TDATA/TUSER  MCTP VDM message packets from UMSG engine.
REQ-007 tx_st_if  pcie_ss_axis_if.source  TDATA/TUSER  merged power-user TX stream toward PCIe SS.
REQ-008 umsg_drop_cnt  output  16  count of UMSG packets discarded for non-message header.

Function
REQ-009 Block SHALL merge the two sinks into tx_st_if at packet granularity; beats of different packets SHALL never interleave.
REQ-010 Arbiter FSM states: IDLE, OWN_MMIO, OWN_UMSG, DROP_UMSG.
REQ-011 IDLE: winner chosen combinationally among valid sinks; only one valid -> that sink; both valid -> sink not granted last (round-robin pointer); pointer after reset = UMSG last, so MMIO wins first tie.
REQ-012 IDLE: winner's first beat SHALL be accepted in the same cycle the decision is made (no arbitration bubble).
REQ-013 First beat with tlast=1 -> stay IDLE; else -> OWN_<winner>, or DROP_UMSG per REQ-016.
REQ-014 OWN_x: only sink x SHALL see tready; on accepted beat with tlast=1 -> IDLE and round-robin pointer = x.
REQ-015 Non-owner sink tready SHALL be 0 at all times outside IDLE-grant.
REQ-016 UMSG first beat whose header fmttype (tdata[HDR_WIDTH-1:0]) is not a VDM message SHALL be discarded: all beats through tlast consumed with tready=1, nothing forwarded, umsg_drop_cnt +1 on the first beat.
REQ-017 umsg_drop_cnt SHALL saturate at 16'hFFFF.
REQ-018 Output stage: one register slice; sink-side ready = ~out_tvalid | tx_st_if.tready; latency first-accepted-beat to tx_st_if.tvalid = 1 cycle.
REQ-019 tdata, tkeep, tlast, tuser_vendor SHALL pass unmodified; forwarded MMIO/UMSG streams sustain 1 beat/clk when tx_st_if.tready=1.
REQ-020 tx_st_if.tvalid SHALL remain asserted with stable payload until tx_st_if.tready=1.
REQ-021 Sink tvalid dropping mid-packet SHALL hold ownership (no re-arbitration until tlast).

Reset
REQ-022 On rst_n=0 asynchronously: state=IDLE, tx_st_if.tvalid=0, rr pointer=UMSG, umsg_drop_cnt=0, all sink treadys=0.
REQ-023 Reset mid-packet SHALL abandon the packet; no partial beats emitted after release; upstream restarts cleanly.
REQ-024 Datapath registers (tdata, tkeep, tuser) need no reset.

Structure
REQ-025 FSM state enum and source-select constants SHALL live in shared st2mm_pkg; header types/functions from pcie_ss_hdr_pkg.
REQ-026 Output register slice SHALL be sub-module st2mm_tx_pipe_reg (1-deep AXI-S pipeline register).
REQ-027 No other sub-modules; arbiter, drop logic and counter in top.

Verification
REQ-028 Single MMIO 1-beat cpl (tlast=1), tready=1 -> tx_st_if.tvalid 1 cycle later, identical tdata; FSM stays IDLE.
REQ-029 MMIO and UMSG 3-beat packets valid same cycle after reset -> MMIO beats 0..2 then UMSG beats 0..2, 6 consecutive cycles, no interleave.
REQ-030 Continuous both-valid 2-beat packets x8 -> strict alternation MMIO/UMSG, 4 each.
REQ-031 UMSG 4-beat packet with MWr fmttype -> 0 beats on tx_st_if, umsg_tready=1 for 4 cycles, umsg_drop_cnt=1; preloaded 16'hFFFF stays 16'hFFFF.
REQ-032 tx_st_if.tready=0 for 5 cycles mid 4-beat MMIO packet -> tvalid held, payload stable, no UMSG beat accepted; resumes on ready.
REQ-033 rst_n asserted during beat 2 of 4-beat UMSG -> tvalid=0 immediately; after release, new MMIO packet forwarded with no stale UMSG beats.
